column_renderer: RTL and testbench

COLUMN_RENDERER -- requirements
Module: column_renderer

---
 rtl/column_renderer.sv | 257 +++++++++++++++++++++++++
 tb/tb_column_renderer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/column_renderer.sv
// -----------------------------------------------------------------------------
// column_renderer
//   Triple-buffered per-column wall descriptor store plus a 3-stage raster
//   pipeline that turns (col,row) requests into ceiling / textured wall / floor
//   pixels. Software fills the WRITE buffer one column at a time over an
//   Avalon-MM slave, commits it, and the committed frame is shown from the next
//   frame_start.
//
// Ports
//   clk, reset_n            single clock, asynchronous active-low reset
//   chipselect/write/read   Avalon-MM slave strobes (zero wait states)
//   address[1:0]            0: COL_LO latch, 1: push column, 2: control, 3: STATUS
//   writedata[31:0]         write data
//   readdata[31:0]          STATUS one cycle after a read of address 3, else 0
//   pix_valid/col/row       raster request
//   frame_start             one-cycle vblank-start pulse
//   tex_addr                {type,row,col} to a texture ROM with 1-cycle read
//   tex_data[23:0]          texel from the ROM
//   rgb[23:0], rgb_valid    pixel result, exactly 3 cycles after pix_valid
// -----------------------------------------------------------------------------
module column_renderer #(
   parameter int          NUM_COLS  = 640,
   parameter int          TEX_BITS  = 6,
   parameter int          FRAC      = 10,
   parameter logic [23:0] CEIL_RGB  = 24'h323232,
   parameter logic [23:0] FLOOR_RGB = 24'h0A0A0A
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      chipselect,
   input  logic                      write,
   input  logic                      read,
   input  logic [1:0]                address,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   input  logic                      pix_valid,
   input  logic [9:0]                pix_col,
   input  logic [9:0]                pix_row,
   input  logic                      frame_start,
   output logic [3+2*TEX_BITS-1:0]   tex_addr,
   input  logic [23:0]               tex_data,
   output logic [23:0]               rgb,
   output logic                      rgb_valid
);

   localparam int          DEPTH   = 3 * NUM_COLS;
   localparam int          AW      = $clog2(DEPTH);
   localparam logic [10:0] NCOLS11 = 11'(NUM_COLS);
   localparam logic [AW-1:0] NC_AW = AW'(NUM_COLS);
   localparam logic [25:0] TEX_MAX = 26'((1 << TEX_BITS) - 1);

   typedef struct packed {
      logic       side;
      logic [2:0] tex_type;
      logic [5:0] tex_col;
      logic [9:0] height;
      logic [9:0] top;
      logic [15:0] step;
   } col_entry_t;

   typedef enum logic [1:0] {PIX_CEIL, PIX_WALL, PIX_FLOOR} pix_kind_e;

   // ---------------- register interface / buffer roles ----------------------
   logic [29:0] r_col_lo;
   logic [10:0] r_wr_ptr;
   logic [1:0]  r_disp_idx, r_write_idx, r_pend_idx;
   logic        r_pend_valid, r_overflow, r_short, r_frame_shown;
   logic [7:0]  r_dropped;
   logic [31:0] r_readdata;

   logic w_wr_en, w_full, w_store, w_commit_req, w_commit_ok, w_clear;
   logic [1:0] w_disp_nxt, w_write_nxt, w_pend_nxt;
   logic w_pend_vld_nxt, w_drop_inc, w_show;
   logic [31:0] w_status;
   logic w_unused;

   assign w_wr_en      = chipselect & write;
   assign w_full       = (r_wr_ptr == NCOLS11);
   assign w_store      = w_wr_en && address == 2'd1 && !w_full;
   assign w_commit_req = w_wr_en && address == 2'd2 && writedata[0];
   assign w_commit_ok  = w_commit_req && w_full;
   assign w_clear      = w_wr_en && address == 2'd2 && writedata[1];
   assign w_unused     = ^writedata[31:30];

   assign w_status = {r_dropped, 7'd0, r_pend_valid, 2'd0, r_short, r_overflow, 1'b0, r_wr_ptr};

   // Role rotation. Index 3-a-b is the one buffer that is neither a nor b.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_disp_nxt     = r_disp_idx;
      w_write_nxt    = r_write_idx;
      w_pend_nxt     = r_pend_idx;
      w_pend_vld_nxt = r_pend_valid;
      w_drop_inc     = 1'b0;
      w_show         = 1'b0;
      if (w_commit_ok && frame_start) begin
         // Committed frame goes straight to the screen; any pending one is lost.
         w_disp_nxt     = r_write_idx;
         w_write_nxt    = r_disp_idx;
         w_pend_vld_nxt = 1'b0;
         w_drop_inc     = r_pend_valid;
         w_show         = 1'b1;
      end else if (w_commit_ok) begin
         w_pend_nxt     = r_write_idx;
         w_pend_vld_nxt = 1'b1;
         if (r_pend_valid) begin
            w_write_nxt = r_pend_idx;
            w_drop_inc  = 1'b1;
         end else begin
            w_write_nxt = 2'd3 - r_disp_idx - r_write_idx;
         end
      end else if (frame_start && r_pend_valid) begin
         w_disp_nxt     = r_pend_idx;
         w_pend_vld_nxt = 1'b0;
         w_show         = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_col_lo      <= '0;
         r_wr_ptr      <= '0;
         r_disp_idx    <= 2'd0;
         r_write_idx   <= 2'd1;
         r_pend_idx    <= 2'd0;
         r_pend_valid  <= 1'b0;
         r_overflow    <= 1'b0;
         r_short       <= 1'b0;
         r_frame_shown <= 1'b0;
         r_dropped     <= '0;
         r_readdata    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_disp_idx   <= w_disp_nxt;
         r_write_idx  <= w_write_nxt;
         r_pend_idx   <= w_pend_nxt;
         r_pend_valid <= w_pend_vld_nxt;
         if (w_show)
            r_frame_shown <= 1'b1;
         if (w_drop_inc && r_dropped != 8'hFF)
            r_dropped <= r_dropped + 8'd1;
         if (w_wr_en && address == 2'd0)
            r_col_lo <= writedata[29:0];

         if (w_commit_ok || w_clear)
            r_wr_ptr <= '0;
         else if (w_store)
            r_wr_ptr <= r_wr_ptr + 11'd1;

         // Clear wins over a flag being set in the same write.
         if (w_clear) begin
            r_overflow <= 1'b0;
            r_short    <= 1'b0;
         end else begin
            if (w_wr_en && address == 2'd1 && w_full)
               r_overflow <= 1'b1;
            if (w_commit_req && !w_full)
               r_short <= 1'b1;
         end

         r_readdata <= (chipselect && read && address == 2'd3) ? w_status : 32'd0;
      end
   end

   assign readdata = r_readdata;

   // ---------------- column buffers (three NUM_COLS banks) ------------------
   col_entry_t       r_mem [DEPTH];
   col_entry_t       r_s1_entry;
   logic [AW-1:0]    w_wr_addr, w_rd_addr;
   logic [9:0]       w_rd_col;
   logic             w_col_oob;

   assign w_col_oob = ({1'b0, pix_col} >= NCOLS11);
   assign w_rd_col  = w_col_oob ? 10'd0 : pix_col;
   assign w_wr_addr = AW'(r_write_idx) * NC_AW + AW'(r_wr_ptr);
   // Stage 1 samples the DISPLAY index here, so a later swap cannot touch this pixel.
   assign w_rd_addr = AW'(r_disp_idx) * NC_AW + AW'(w_rd_col);

   // NOTE: buffer contents and the read register carry no reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_store)
         r_mem[w_wr_addr] <= {r_col_lo, writedata[15:0]};
      r_s1_entry <= r_mem[w_rd_addr];
   end

   // ---------------- pixel pipeline -----------------------------------------
   logic       r_s1_valid, r_s1_blank;
   logic [9:0] r_s1_row;
   logic       r_s2_valid, r_s2_blank, r_s2_side;
   pix_kind_e  r_s2_kind;
   logic [23:0] r_rgb;
   logic        r_rgb_valid;

   pix_kind_e      w_kind;
   logic [10:0]    w_wall_end;
   logic [9:0]     w_dist;
   logic [25:0]    w_prod, w_shift;
   logic [TEX_BITS-1:0] w_texrow;

   always_comb begin
      w_wall_end = {1'b0, r_s1_entry.top} + {1'b0, r_s1_entry.height};
      w_dist     = r_s1_row - r_s1_entry.top;
      w_prod     = 26'(w_dist) * 26'(r_s1_entry.step);
      w_shift    = w_prod >> FRAC;
      w_texrow   = (w_shift > TEX_MAX) ? TEX_MAX[TEX_BITS-1:0] : w_shift[TEX_BITS-1:0];
      if (r_s1_row < r_s1_entry.top)
         w_kind = PIX_CEIL;
      else if ({1'b0, r_s1_row} < w_wall_end)
         w_kind = PIX_WALL;
      else
         w_kind = PIX_FLOOR;
   end

   // Address is presented during stage 2 so the ROM's registered data lands in stage 3.
   assign tex_addr = r_s1_valid ?
                     {r_s1_entry.tex_type, w_texrow, r_s1_entry.tex_col[TEX_BITS-1:0]} : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_blank  <= 1'b1;
         r_s1_row    <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_blank  <= 1'b1;
         r_s2_side   <= 1'b0;
         r_s2_kind   <= PIX_FLOOR;
         r_rgb       <= '0;
         r_rgb_valid <= 1'b0;
      end else begin
         r_s1_valid <= pix_valid;
         r_s1_blank <= w_col_oob || !r_frame_shown;
         r_s1_row   <= pix_row;

         r_s2_valid <= r_s1_valid;
         r_s2_blank <= r_s1_blank;
         r_s2_side  <= r_s1_entry.side;
         r_s2_kind  <= w_kind;

         r_rgb_valid <= r_s2_valid;
         if (!r_s2_valid || r_s2_blank)
            r_rgb <= '0;
         else if (r_s2_kind == PIX_CEIL)
            r_rgb <= CEIL_RGB;
         else if (r_s2_kind == PIX_FLOOR)
            r_rgb <= FLOOR_RGB;
         else if (r_s2_side)
            r_rgb <= tex_data;
         else
            r_rgb <= {1'b0, tex_data[23:17], 1'b0, tex_data[15:9], 1'b0, tex_data[7:1]};
      end
   end

   assign rgb       = r_rgb;
   assign rgb_valid = r_rgb_valid;

endmodule

// File: tb/tb_column_renderer.sv
// -----------------------------------------------------------------------------
// tb_column_renderer
//   Directed bench for column_renderer at default parameters. The texture ROM
//   model returns {9'd0, tex_addr} one cycle after the address, so a wall
//   pixel's rgb exposes {type,texrow,texcol}; a constant-texel mode returns
//   0xFF8040 for the half-brightness check.
// -----------------------------------------------------------------------------
module tb_column_renderer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        chipselect, write, read;
   logic [1:0]  address;
   logic [31:0] writedata, readdata;
   logic        pix_valid, frame_start;
   logic [9:0]  pix_col, pix_row;
   logic [14:0] tex_addr;
   logic [23:0] tex_data;
   logic [23:0] rgb;
   logic        rgb_valid;

   logic rom_const;
   int   n_checks = 0;
   int   n_pass   = 0;

   column_renderer dut (
      .clk(clk), .reset_n(reset_n),
      .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata),
      .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row),
      .frame_start(frame_start),
      .tex_addr(tex_addr), .tex_data(tex_data),
      .rgb(rgb), .rgb_valid(rgb_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      tex_data <= rom_const ? 24'hFF8040 : {9'd0, tex_addr};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] col_lo(input logic side, input logic [2:0] ty,
                                          input logic [5:0] tc, input logic [9:0] h,
                                          input logic [9:0] top);
      return {2'b00, side, ty, tc, h, top};
   endfunction

   function automatic logic [31:0] st(input logic [7:0] drop, input logic pend,
                                      input logic shrt, input logic ovf,
                                      input logic [10:0] ptr);
      return {drop, 7'd0, pend, 2'd0, shrt, ovf, 1'b0, ptr};
   endfunction

   task automatic avm_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic avm_rd(input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      v = readdata;
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp);
      logic [31:0] v;
      avm_rd(2'd3, v);
      check(tag, v, exp);
   endtask

   task automatic load_frame(input int n, input logic [31:0] lo, input logic [15:0] step);
      avm_wr(2'd0, lo);
      for (int i = 0; i < n; i++) avm_wr(2'd1, {16'd0, step});
   endtask

   task automatic pulse_fs();
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
   endtask

   // Issue one pixel and sample at the third negedge after it was launched.
   task automatic check_pixel(input string tag, input logic [9:0] c, input logic [9:0] r,
                              input logic [23:0] exp);
      @(negedge clk);
      pix_valid = 1'b1; pix_col = c; pix_row = r;
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({tag, ".valid"}, {31'd0, rgb_valid}, 32'd1);
      check(tag, {8'd0, rgb}, {8'd0, exp});
   endtask

   initial begin
      logic [31:0] v;
      int          n_seen;

      reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = '0; writedata = '0; pix_valid = 1'b1; pix_col = 10'd10;
      pix_row = 10'd150; frame_start = 1'b0; rom_const = 1'b0;

      // Reset state, with a request held during reset.
      repeat (4) @(negedge clk);
      check("rst.rgb",       {8'd0, rgb},        32'd0);
      check("rst.rgb_valid", {31'd0, rgb_valid}, 32'd0);
      check("rst.readdata",  readdata,           32'd0);
      check("rst.tex_addr",  {17'd0, tex_addr},  32'd0);
      pix_valid = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      check_status("rst.status", st(0, 0, 0, 0, 0));

      // Nothing shown yet: blank output but valid still flows.
      check_pixel("pre_show", 10'd10, 10'd150, 24'h000000);

      // Frame A: top=100 height=200 step=0x147 side=1 type=3 texcol=5.
      load_frame(640, col_lo(1'b1, 3'd3, 6'd5, 10'd200, 10'd100), 16'h0147);
      check_status("A.full", st(0, 0, 0, 0, 640));
      avm_wr(2'd2, 32'd1);
      check_status("A.committed", st(0, 1, 0, 0, 0));
      pulse_fs();
      check_status("A.shown", st(0, 0, 0, 0, 0));

      // Latency: nothing at the second negedge, result at the third.
      @(negedge clk);
      pix_valid = 1'b1; pix_col = 10'd10; pix_row = 10'd99;
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      check("lat.early", {31'd0, rgb_valid}, 32'd0);
      @(negedge clk);
      check("lat.valid", {31'd0, rgb_valid}, 32'd1);
      check("A.row99", {8'd0, rgb}, 32'h00323232);

      check_pixel("A.row100", 10'd10,  10'd100, 24'h003005);
      check_pixel("A.row200", 10'd10,  10'd200, 24'h0037C5);
      check_pixel("A.row299", 10'd10,  10'd299, 24'h003FC5);
      check_pixel("A.row300", 10'd10,  10'd300, 24'h0A0A0A);
      check_pixel("A.col639", 10'd639, 10'd100, 24'h003005);

      avm_rd(2'd0, v);
      check("rd.addr0", v, 32'd0);

      // Short frame: commit after 639 columns is refused.
      load_frame(639, col_lo(1'b1, 3'd5, 6'd5, 10'd200, 10'd100), 16'h0147);
      avm_wr(2'd2, 32'd1);
      check_status("short.status", st(0, 0, 1, 0, 639));
      pulse_fs();
      check_pixel("short.display", 10'd10, 10'd100, 24'h003005);
      avm_wr(2'd2, 32'd2);
      check_status("short.clear", st(0, 0, 0, 0, 0));

      // Two full commits before one frame_start: the first is dropped.
      load_frame(640, col_lo(1'b1, 3'd1, 6'd5, 10'd200, 10'd100), 16'h0147);
      avm_wr(2'd2, 32'd1);
      load_frame(640, col_lo(1'b1, 3'd2, 6'd5, 10'd200, 10'd100), 16'h0800);
      avm_wr(2'd2, 32'd1);
      check_status("drop.status", st(1, 1, 0, 0, 0));
      pulse_fs();
      check_status("drop.shown", st(1, 0, 0, 0, 0));
      check_pixel("C.row110", 10'd10, 10'd110, 24'h002505);
      check_pixel("C.row140.sat", 10'd10, 10'd140, 24'h002FC5);

      // Commit and frame_start in the same cycle.
      load_frame(640, col_lo(1'b1, 3'd4, 6'd5, 10'd200, 10'd100), 16'h0147);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'd1; frame_start = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; frame_start = 1'b0;
      check_status("same.status", st(1, 0, 0, 0, 0));
      check_pixel("D.row100", 10'd10, 10'd100, 24'h004005);

      // Overflow on the 641st column, cleared by control bit 1.
      load_frame(641, col_lo(1'b1, 3'd6, 6'd5, 10'd200, 10'd100), 16'h0147);
      check_status("ovf.status", st(1, 0, 0, 1, 640));
      avm_wr(2'd2, 32'd2);
      check_status("ovf.clear", st(1, 0, 0, 0, 0));
      check_pixel("ovf.display", 10'd10, 10'd100, 24'h004005);

      // side=0 halves the texel; out-of-range column is black.
      load_frame(640, col_lo(1'b0, 3'd7, 6'd9, 10'd200, 10'd100), 16'h0147);
      avm_wr(2'd2, 32'd1);
      pulse_fs();
      rom_const = 1'b1;
      check_pixel("E.half",  10'd10,  10'd150, 24'h7F4020);
      check_pixel("E.col700", 10'd700, 10'd150, 24'h000000);
      check_pixel("E.ceil",  10'd10,  10'd50,  24'h323232);
      check_pixel("E.floor", 10'd10,  10'd350, 24'h0A0A0A);
      rom_const = 1'b0;

      // Reset mid-frame with a pixel in flight.
      load_frame(100, col_lo(1'b1, 3'd1, 6'd1, 10'd10, 10'd10), 16'h0147);
      @(negedge clk);
      pix_valid = 1'b1; pix_col = 10'd10; pix_row = 10'd150;
      @(negedge clk);
      pix_valid = 1'b0; reset_n = 1'b0;
      n_seen = 0;
      @(negedge clk);
      if (rgb_valid) n_seen++;
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rgb_valid) n_seen++;
      end
      check("midrst.no_valid", 32'(n_seen), 32'd0);
      check_status("midrst.status", st(0, 0, 0, 0, 0));
      check_pixel("midrst.blank", 10'd10, 10'd150, 24'h000000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
